add_tree_accum: RTL and testbench

ADD_TREE_ACCUM -- requirements
Module: add_tree_accum

---
 rtl/add_tree_accum.sv | 106 ++++++++++
 tb/tb_add_tree_accum.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/add_tree_accum.sv
// Per-lane adder tree over one beat of products, followed by a bias-seeded accumulator that emits one
// narrowed result every ACC_GROUPS beats. Define ACCUM_SATURATE_EN to clamp results instead of wrapping.
module add_tree_accum #(
   parameter int Kh         = 3,
   parameter int Kw         = 3,
   parameter int Pin        = 2,
   parameter int Pout       = 1,
   parameter int BIT_WIDTH  = 8,
   parameter int ACC_GROUPS = 4
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  mult_array_valid,
   input  logic [Pout*Pin*Kh*Kw*BIT_WIDTH-1:0]   mult_array_data,
   input  logic [Pout*BIT_WIDTH-1:0]             bias_in,
   input  logic                                  accum_clear,
   output logic                                  accum_valid,
   output logic [Pout*BIT_WIDTH-1:0]             accum_data
);

   localparam int N         = Pin * Kh * Kw;
   localparam int ACC_WIDTH = 2 * BIT_WIDTH + $clog2(N * ACC_GROUPS) + 1;
   localparam int CNT_W     = (ACC_GROUPS > 1) ? $clog2(ACC_GROUPS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_GROUPS - 1);
`ifdef ACCUM_SATURATE_EN
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (BIT_WIDTH - 1)) - 1);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
`endif

   logic signed [ACC_WIDTH-1:0] psum_q [Pout];
   logic signed [ACC_WIDTH-1:0] psum_d [Pout];
   logic signed [ACC_WIDTH-1:0] acc_q  [Pout];
   logic signed [ACC_WIDTH-1:0] acc_d  [Pout];
   logic                        psum_valid_q;
   logic [CNT_W-1:0]            cnt_q;
   logic [CNT_W-1:0]            cnt_d;
   logic                        accum_valid_q;
   logic [Pout*BIT_WIDTH-1:0]   accum_data_q;
   logic [Pout*BIT_WIDTH-1:0]   result_d;
   logic [BIT_WIDTH-1:0]        prod;
   logic [BIT_WIDTH-1:0]        bias_lane;

   // acc_d is the running sum including the current psum; on the last group it is the final sum.
   always_comb begin
      prod      = '0;
      bias_lane = '0;
      result_d  = '0;
      cnt_d     = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
      for (int i = 0; i < Pout; i++) begin
         psum_d[i] = '0;
         for (int n = 0; n < N; n++) begin
            prod      = mult_array_data[(i*N+n)*BIT_WIDTH +: BIT_WIDTH];
            psum_d[i] = psum_d[i] + {{(ACC_WIDTH-BIT_WIDTH){prod[BIT_WIDTH-1]}}, prod};
         end
         bias_lane = bias_in[i*BIT_WIDTH +: BIT_WIDTH];
         acc_d[i]  = ((cnt_q == '0) ? {{(ACC_WIDTH-BIT_WIDTH){bias_lane[BIT_WIDTH-1]}}, bias_lane}
                                    : acc_q[i]) + psum_q[i];
`ifdef ACCUM_SATURATE_EN
         if (acc_d[i] > SAT_MAX)
            result_d[i*BIT_WIDTH +: BIT_WIDTH] = SAT_MAX[BIT_WIDTH-1:0];
         else if (acc_d[i] < SAT_MIN)
            result_d[i*BIT_WIDTH +: BIT_WIDTH] = SAT_MIN[BIT_WIDTH-1:0];
         else
            result_d[i*BIT_WIDTH +: BIT_WIDTH] = acc_d[i][BIT_WIDTH-1:0];
`else
         result_d[i*BIT_WIDTH +: BIT_WIDTH] = acc_d[i][BIT_WIDTH-1:0];
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         psum_valid_q  <= 1'b0;
         cnt_q         <= '0;
         accum_valid_q <= 1'b0;
         accum_data_q  <= '0;
         for (int i = 0; i < Pout; i++) begin
            psum_q[i] <= '0;
            acc_q[i]  <= '0;
         end
      end else begin
         accum_valid_q <= 1'b0;
         if (accum_clear) begin
            // Clear wins over an arriving beat and over a psum already in flight.
            psum_valid_q <= 1'b0;
            cnt_q        <= '0;
            for (int i = 0; i < Pout; i++) acc_q[i] <= '0;
         end else begin
            psum_valid_q <= mult_array_valid;
            if (mult_array_valid) psum_q <= psum_d;
            if (psum_valid_q) begin
               cnt_q <= cnt_d;
               acc_q <= acc_d;
               if (cnt_q == LAST) begin
                  accum_data_q  <= result_d;
                  accum_valid_q <= 1'b1;
               end
            end
         end
      end
   end

   assign accum_valid = accum_valid_q;
   assign accum_data  = accum_data_q;

endmodule

// File: tb/tb_add_tree_accum.sv
// Directed bench for add_tree_accum (8-bit, 2x3x3, one lane, two groups per pixel); expected
// pixel results are queued when the final beat is driven and compared whenever accum_valid rises.
module tb_add_tree_accum;

   localparam int BW  = 8;
   localparam int NEL = 18;
   localparam int DW  = NEL * BW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          mult_array_valid;
   logic [DW-1:0] mult_array_data;
   logic [BW-1:0] bias_in;
   logic          accum_clear;
   logic          accum_valid;
   logic [BW-1:0] accum_data;

   logic [BW-1:0] exp_q[$];
   logic [BW-1:0] exp_item;
   int            n_checks = 0;
   int            n_fail   = 0;

   add_tree_accum #(
      .Kh(3), .Kw(3), .Pin(2), .Pout(1), .BIT_WIDTH(BW), .ACC_GROUPS(2)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .mult_array_valid (mult_array_valid),
      .mult_array_data  (mult_array_data),
      .bias_in          (bias_in),
      .accum_clear      (accum_clear),
      .accum_valid      (accum_valid),
      .accum_data       (accum_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [BW-1:0] narrow(input int s);
      logic [31:0] v;
`ifdef ACCUM_SATURATE_EN
      if (s > 127) return 8'h7F;
      if (s < -128) return 8'h80;
`endif
      v = s;
      return v[BW-1:0];
   endfunction

   function automatic int beat_sum(input logic [DW-1:0] d);
      int  s;
      byte b;
      s = 0;
      for (int n = 0; n < NEL; n++) begin
         b = d[n*BW +: BW];
         s += b;
      end
      return s;
   endfunction

   // Scoreboard: every result strobe must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && accum_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 32'd1, 32'd0);
         end else begin
            exp_item = exp_q.pop_front();
            check("accum_data", {24'd0, accum_data}, {24'd0, exp_item});
         end
      end
   end

   task automatic drive_vec(input logic [DW-1:0] d, input logic [BW-1:0] b);
      mult_array_data  = d;
      bias_in          = b;
      mult_array_valid = 1'b1;
      @(posedge clk);
      #1 mult_array_valid = 1'b0;
   endtask

   task automatic drive_beat(input logic [BW-1:0] p, input logic [BW-1:0] b);
      drive_vec({NEL{p}}, b);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called right after the final beat's sampling edge: strobe must land one edge later for one cycle.
   task automatic check_timing(input string tag);
      @(negedge clk); check({tag, "_valid_early"}, {31'd0, accum_valid}, 32'd0);
      @(negedge clk); check({tag, "_valid_on_time"}, {31'd0, accum_valid}, 32'd1);
      @(negedge clk); check({tag, "_valid_one_cycle"}, {31'd0, accum_valid}, 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [DW-1:0] d0;
      logic [DW-1:0] d1;
      logic [BW-1:0] rb;
      rst_n            = 1'b0;
      mult_array_valid = 1'b0;
      mult_array_data  = '0;
      bias_in          = '0;
      accum_clear      = 1'b0;
      #1;
      check("reset_valid", {31'd0, accum_valid}, 32'd0);
      check("reset_data", {24'd0, accum_data}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Two back-to-back beats of ones, bias 0 -> 36.
      exp_q.push_back(8'h24);
      drive_beat(8'h01, 8'h00);
      drive_beat(8'h01, 8'h00);
      check_timing("ones");

      // Asynchronous reset mid-pixel clears outputs at once and restarts grouping.
      drive_beat(8'h01, 8'h00);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_reset_valid", {31'd0, accum_valid}, 32'd0);
      check("async_reset_data", {24'd0, accum_data}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      exp_q.push_back(8'h24);
      drive_beat(8'h01, 8'h00);
      drive_beat(8'h01, 8'h00);
      check_timing("post_reset");

      // Large positive sum: saturates or wraps.
      exp_q.push_back(narrow(4572));
      drive_beat(8'h7F, 8'h00);
      drive_beat(8'h7F, 8'h00);
      check_timing("pos_big");

      // All -1 with bias 5 -> -31 in both configurations.
      exp_q.push_back(8'hE1);
      drive_beat(8'hFF, 8'h05);
      drive_beat(8'hFF, 8'h05);
      check_timing("neg_bias");

      // Idle gap between the two beats of a pixel.
      drive_beat(8'h01, 8'h00);
      idle(3);
      exp_q.push_back(8'h24);
      drive_beat(8'h01, 8'h00);
      check_timing("gap");

      // Clear after a lone beat discards it.
      drive_beat(8'h10, 8'h00);
      accum_clear = 1'b1;
      @(posedge clk); #1;
      accum_clear = 1'b0;
      exp_q.push_back(8'h24);
      drive_beat(8'h01, 8'h00);
      drive_beat(8'h01, 8'h00);
      check_timing("clear");

      // A beat presented together with clear is dropped.
      accum_clear = 1'b1;
      drive_beat(8'h10, 8'h00);
      accum_clear = 1'b0;
      exp_q.push_back(8'h24);
      drive_beat(8'h01, 8'h00);
      drive_beat(8'h01, 8'h00);
      check_timing("clear_with_beat");

      // Random pixels streamed back-to-back with no gaps.
      for (int r = 0; r < 4; r++) begin
         for (int n = 0; n < NEL; n++) begin
            d0[n*BW +: BW] = BW'($urandom_range(0, 255));
            d1[n*BW +: BW] = BW'($urandom_range(0, 255));
         end
         rb = BW'($urandom_range(0, 255));
         exp_q.push_back(narrow(int'($signed(rb)) + beat_sum(d0) + beat_sum(d1)));
         drive_vec(d0, rb);
         drive_vec(d1, rb);
      end

      for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
      check("queue_drained", exp_q.size(), 32'd0);
      idle(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
